// File: rtl/inst_encode_loader.sv
// inst_encode_loader: packs control-level instruction descriptions into 32-bit words and writes them to consecutive instruction-memory addresses.
// Optional ENC_LOADER_CHECK_EN: illegal combinations are dropped and flagged on err instead of written as NOP.
module inst_encode_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              Is_Imm,
  input  logic              WB_En,
  input  logic              MEM_R_En,
  input  logic              MEM_W_En,
  input  logic [3:0]        EXE_Cmd,
  input  logic [1:0]        BR_Type,
  input  logic [4:0]        Dest,
  input  logic [4:0]        Src1,
  input  logic [4:0]        Src2,
  input  logic [15:0]       Imm,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;
`ifdef ENC_LOADER_CHECK_EN
  localparam logic check_en = 1'b1;
`else
  localparam logic check_en = 1'b0;
`endif
  localparam logic [ADDR_W:0] one = {{ADDR_W{1'b0}}, 1'b1};
  state_t state, state_n;
  logic [5:0] op;
  logic [31:0] word;
  logic legal, hs, accept, err_q;
  always_comb begin
    legal = 1'b1;
    op = 6'd0;
    if (BR_Type != 2'b00) op = 6'd39 + {4'd0, BR_Type};
    else if (MEM_R_En) op = 6'd36;
    else if (MEM_W_En) op = 6'd37;
    else if (Is_Imm && WB_En) begin
      op = (EXE_Cmd == 4'b0000) ? 6'd32 : 6'd33;
      legal = (EXE_Cmd == 4'b0000) || (EXE_Cmd == 4'b0010);
    end else if (WB_En) begin
      case (EXE_Cmd)
        4'b0000: op = 6'd1;
        4'b0010: op = 6'd3;
        4'b0100: op = 6'd5;
        4'b0101: op = 6'd6;
        4'b0110: op = 6'd7;
        4'b0111: op = 6'd8;
        4'b1000: op = 6'd9;
        4'b1001: op = 6'd11;
        4'b1010: op = 6'd12;
        default: legal = 1'b0;
      endcase
    end else legal = !(Is_Imm || (|EXE_Cmd));
    if (!legal) op = 6'd0;
  end
  // opcodes 32 and up are I-type and carry the immediate in the low half
  assign word = op[5] ? {op, Dest, Src1, Imm} : {op, Dest, Src1, Src2, 11'd0};
  assign in_ready = (state == IDLE) && !rst;
  assign hs = in_valid && in_ready;
  assign accept = hs && (legal || !check_en);
  assign mem_wr_en = (state == WRITE);
  assign full = (state == FULL);
  assign err = err_q;
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = WRITE;
    else if (state == WRITE) state_n = (&wr_count[ADDR_W-1:0]) ? FULL : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_count <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        mem_addr <= wr_count[ADDR_W-1:0];
        mem_wdata <= word;
      end
      if (state == WRITE) wr_count <= wr_count + one;
      if (hs && !legal && check_en) err_q <= 1'b1;
    end
  end
endmodule

// File: doc/inst_encode_loader.md
# inst_encode_loader

Instruction encoder and loader for the pipelined processor's instruction memory, the inverse of the ID-stage control unit. It accepts instructions described at control-signal level (Is_Imm, WB_En, MEM_R_En, MEM_W_En, EXE_Cmd, BR_Type) plus register and immediate fields, and maps them back to the 6-bit opcode. It packs each into a 32-bit instruction word and writes it to consecutive instruction-memory words. It sits between the test/boot source and the instruction-memory write port.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2**ADDR_W words
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  source presents an instruction
- in_ready  output  1  block can accept; transfer on in_valid & in_ready at rising clk
- Is_Imm, WB_En, MEM_R_En, MEM_W_En  input  1 each  control-level description
- EXE_Cmd  input  4  ALU command
- BR_Type  input  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- Dest, Src1, Src2  input  5 each  register fields
- Imm  input  16  immediate
- mem_wr_en  output  1  instruction-memory write strobe
- mem_addr  output  ADDR_W  word address
- mem_wdata  output  32  encoded instruction
- wr_count  output  ADDR_W+1  words written since reset
- full  output  1  memory full, no further accepts
- err  output  1  sticky, illegal combination seen

## Operation
- Opcode mapping, first match wins:
  - BR_Type 01/10/11 -> 40/41/42
  - MEM_R_En -> LD 36
  - MEM_W_En -> ST 37
  - Is_Imm & WB_En & EXE_Cmd 0000/0010 -> ADDI 32 / SUBI 33
  - !Is_Imm & WB_En & EXE_Cmd 0000/0010/0100/0101/0110/0111/1000/1001/1010 -> 1/3/5/6/7/8/9(SLA)/11/12
  - all control inputs zero -> NOP 0
  - anything else -> illegal
- SLL (10) is not producible, because EXE_Cmd 1000 always encodes as SLA.
- Word format: [31:26] opcode, [25:21] Dest, [20:16] Src1.
  - R-type (opcodes 0–12): [15:11] Src2, [10:0] zero.
  - I-type (32–42): [15:0] Imm.
- FSM states:
  - IDLE: in_ready=1. On handshake, latch the encoded word and go to WRITE.
  - WRITE: in_ready=0, mem_wr_en=1 for exactly one cycle at mem_addr=ptr, mem_wdata=latched word. Then ptr+1 and wr_count+1. If ptr was 2**ADDR_W-1, go to FULL; else go to IDLE.
  - FULL: in_ready=0, full=1, mem_wr_en=0. Only rst leaves FULL.
- ptr never wraps; the FULL state prevents overwrite of word 0.
- An illegal combination is handled per Configuration.

## Timing
- Reset values: in_ready=0 during the rst cycle, then 1 in IDLE. mem_wr_en=0, mem_addr=0, mem_wdata=0, wr_count=0, full=0, err=0, state IDLE.
- Handshake at edge N -> mem_wr_en high in cycle N+1 -> in_ready high again in cycle N+2. Throughput is one instruction per 2 cycles.
- mem_addr and mem_wdata are registered and hold their value outside WRITE.
- Inputs are sampled only at the handshake edge. Changes while in_ready=0 are ignored.
- rst during WRITE: the write is squashed, and mem_wr_en=0 in the cycle after the rst edge.
- full rises in the cycle after the final write. wr_count then reads 2**ADDR_W.

## Configuration
- ENC_LOADER_CHECK_EN defined:
  - An illegal combination is accepted, not written, and ptr is unchanged.
  - err is set (sticky) and the FSM returns IDLE -> IDLE with no WRITE cycle. in_ready stays 1.
- ENC_LOADER_CHECK_EN undefined:
  - An illegal combination encodes as NOP (opcode 0, register fields packed) and is written normally.
  - err is tied to 0.

## Test plan
- ADD: WB_En=1, EXE_Cmd=0000, Dest=1, Src1=2, Src2=3 -> one write at addr 0 of 0x04221800; wr_count=1.
- ADDI then BNE:
  - ADDI: Is_Imm=1, WB_En=1, EXE_Cmd=0000, Dest=4, Src1=0, Imm=0x0010 -> 0x80800010 at addr 0.
  - BNE: BR_Type=10, Is_Imm=1, Dest=1, Src1=2, Imm=0xFFFE -> 0xA422FFFE at addr 1.
- Back-to-back in_valid held high for 4 instructions -> mem_wr_en pulses every second cycle; in_ready low during each pulse; addresses 0..3.
- ADDR_W=2, 5 valid instructions -> 4 writes, full=1 after the 4th, the 5th never handshakes, and wr_count=4.
- Illegal input (Is_Imm=1, WB_En=1, EXE_Cmd=0101):
  - With ENC_LOADER_CHECK_EN: err=1 and no write.
  - Without it: 0x0000_0000 plus fields is written.
- rst asserted in WRITE cycle -> no mem_wr_en after the edge, and all outputs return to their reset values.
